// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two sources (ALU, LSU) and the regfile write-port arbiter.
// Carries both source request channels and the registered regfile write port.
// The arbiter uses the slave modport; the source side and regfile use the master modport.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // src0 (ALU) request channel
    logic              s0_valid;
    logic              s0_ready;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_data;

    // src1 (LSU) request channel
    logic              s1_valid;
    logic              s1_ready;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;

    // registered regfile write port
    logic              w_enable;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    modport slave (
        input  s0_valid, s0_addr, s0_data,
        output s0_ready,
        input  s1_valid, s1_addr, s1_data,
        output s1_ready,
        output w_enable, w_addr, w_data
    );

    modport master (
        output s0_valid, s0_addr, s0_data,
        input  s0_ready,
        output s1_valid, s1_addr, s1_data,
        input  s1_ready,
        input  w_enable, w_addr, w_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU (src0) and LSU (src1).
// Latency: one cycle from accept edge to w_* presenting the write; regfile commits at the next edge.
// Backpressure: combinational ready grant, at most one per cycle; rdy=0 drops both readies and freezes all state.
// Optional busy-register scoreboard is enabled with the WB_SCOREBOARD_EN macro.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    regfile_wb_arbiter_if.slave   bus
`ifdef WB_SCOREBOARD_EN
    ,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_rd,
    input  logic [ADDR_W-1:0]     q1_addr,
    input  logic [ADDR_W-1:0]     q2_addr,
    output logic                  q1_busy,
    output logic                  q2_busy
`endif
);

    // prio: 0 prefers src0, 1 prefers src1 when both are valid
    logic              prio;
    logic              grant0;
    logic              grant1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              w_enable_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [DATA_W-1:0] w_data_q;

    // Grant: only while out of reset and globally ready; prio breaks ties
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (rst && rdy) begin
            grant0 = bus.s0_valid && (!bus.s1_valid || !prio);
            grant1 = bus.s1_valid && (!bus.s0_valid ||  prio);
        end
        xfer     = grant0 || grant1;
        sel_addr = grant1 ? bus.s1_addr : bus.s0_addr;
        sel_data = grant1 ? bus.s1_data : bus.s0_data;
    end

    assign bus.s0_ready = grant0;
    assign bus.s1_ready = grant1;
    assign bus.w_enable = w_enable_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.w_data   = w_data_q;

    // Register the granted write; writes to x0 are accepted but never enabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_enable_q <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            prio       <= 1'b0;
        end else if (rdy) begin
            w_enable_q <= xfer && (sel_addr != '0);
            if (xfer) begin
                w_addr_q <= sel_addr;
                w_data_q <= sel_data;
                // granted src0 -> prefer src1 next, and vice versa
                prio     <= grant0;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Next busy vector: clear on committing write, then set on issue so set wins
    always_comb begin
        busy_nxt = busy;
        if (w_enable_q) begin
            busy_nxt[w_addr_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy vector state; frozen while rdy is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else if (rdy) begin
            busy <= busy_nxt;
        end
    end

    // Lookups see the current vector only, no same-cycle bypass
    assign q1_busy = busy[q1_addr];
    assign q2_busy = busy[q2_addr];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Scoreboard scenario is included when WB_SCOREBOARD_EN is defined.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef WB_SCOREBOARD_EN
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_rd    = '0;
    logic [AW-1:0] q1_addr   = '0;
    logic [AW-1:0] q2_addr   = '0;
    logic          q1_busy;
    logic          q2_busy;
`endif

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
`ifdef WB_SCOREBOARD_EN
        ,
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .q1_addr   (q1_addr),
        .q2_addr   (q2_addr),
        .q1_busy   (q1_busy),
        .q2_busy   (q2_busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.s0_valid = v0;
        bus.s0_addr  = a0;
        bus.s0_data  = d0;
        bus.s1_valid = v1;
        bus.s1_addr  = a1;
        bus.s1_data  = d1;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1'b1, 5'd9, 32'h1111_1111, 1'b1, 5'd10, 32'h2222_2222);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({bus.s0_ready, bus.s1_ready} !== 2'b00) begin
                $display("FAIL reset_ready[%0d]: got %b want 00", i, {bus.s0_ready, bus.s1_ready});
                n_fail++;
            end
            cyc();
            #1;
            n_cmp++;
            if ({bus.w_enable, bus.w_addr, bus.w_data} !== {1'b0, 5'd0, 32'h0}) begin
                $display("FAIL reset_w[%0d]: got en=%b addr=%0d data=%h want 0/0/0",
                         i, bus.w_enable, bus.w_addr, bus.w_data);
                n_fail++;
            end
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_single;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
        n_cmp++;
        if ({bus.s0_ready, bus.s1_ready} !== 2'b10) begin
            $display("FAIL single_ready: got %b want 10", {bus.s0_ready, bus.s1_ready});
            n_fail++;
        end
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_cmp++;
        if ({bus.w_enable, bus.w_addr, bus.w_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            $display("FAIL single_w: got en=%b addr=%0d data=%h want 1/5/deadbeef",
                     bus.w_enable, bus.w_addr, bus.w_data);
            n_fail++;
        end
        cyc();
        n_cmp++;
        if (bus.w_enable !== 1'b0) begin
            $display("FAIL single_idle: got en=%b want 0", bus.w_enable);
            n_fail++;
        end
    endtask

    task automatic test_round_robin;
        logic [1:0]    exp_rdy  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [AW-1:0] exp_addr [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
        logic [DW-1:0] exp_data [4] = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hA0A0_A0A0, 32'hB1B1_B1B1};
        // re-reset so prio starts at src0
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'hA0A0_A0A0, 1'b1, 5'd2, 32'hB1B1_B1B1);
            n_cmp++;
            if ({bus.s0_ready, bus.s1_ready} !== exp_rdy[i]) begin
                $display("FAIL rr_ready[%0d]: got %b want %b", i, {bus.s0_ready, bus.s1_ready}, exp_rdy[i]);
                n_fail++;
            end
            cyc();
            n_cmp++;
            if ({bus.w_enable, bus.w_addr, bus.w_data} !== {1'b1, exp_addr[i], exp_data[i]}) begin
                $display("FAIL rr_w[%0d]: got en=%b addr=%0d data=%h want 1/%0d/%h",
                         i, bus.w_enable, bus.w_addr, bus.w_data, exp_addr[i], exp_data[i]);
                n_fail++;
            end
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_addr_zero;
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234);
        n_cmp++;
        if ({bus.s0_ready, bus.s1_ready} !== 2'b01) begin
            $display("FAIL x0_ready: got %b want 01", {bus.s0_ready, bus.s1_ready});
            n_fail++;
        end
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_cmp++;
        if (bus.w_enable !== 1'b0) begin
            $display("FAIL x0_w_enable: got %b want 0", bus.w_enable);
            n_fail++;
        end
    endtask

    task automatic test_stall;
        drive(1'b1, 5'd7, 32'h0000_0077, 1'b0, '0, '0);
        n_cmp++;
        if ({bus.s0_ready, bus.s1_ready} !== 2'b10) begin
            $display("FAIL stall_accept: got %b want 10", {bus.s0_ready, bus.s1_ready});
            n_fail++;
        end
        cyc();
        // both sources now pending while the write to r7 is held
        rdy = 1'b0;
        drive(1'b1, 5'd8, 32'h0000_0088, 1'b1, 5'd9, 32'h0000_0099);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus.s0_ready, bus.s1_ready} !== 2'b00) begin
                $display("FAIL stall_ready[%0d]: got %b want 00", i, {bus.s0_ready, bus.s1_ready});
                n_fail++;
            end
            n_cmp++;
            if ({bus.w_enable, bus.w_addr, bus.w_data} !== {1'b1, 5'd7, 32'h0000_0077}) begin
                $display("FAIL stall_hold[%0d]: got en=%b addr=%0d data=%h want 1/7/00000077",
                         i, bus.w_enable, bus.w_addr, bus.w_data);
                n_fail++;
            end
            cyc();
        end
        rdy = 1'b1;
        #1;
        // src0 was granted last, so src1 wins the tie
        n_cmp++;
        if ({bus.s0_ready, bus.s1_ready} !== 2'b01) begin
            $display("FAIL stall_resume_ready: got %b want 01", {bus.s0_ready, bus.s1_ready});
            n_fail++;
        end
        cyc();
        n_cmp++;
        if ({bus.w_enable, bus.w_addr, bus.w_data} !== {1'b1, 5'd9, 32'h0000_0099}) begin
            $display("FAIL stall_resume_w1: got en=%b addr=%0d data=%h want 1/9/00000099",
                     bus.w_enable, bus.w_addr, bus.w_data);
            n_fail++;
        end
        drive(1'b1, 5'd8, 32'h0000_0088, 1'b0, '0, '0);
        n_cmp++;
        if ({bus.s0_ready, bus.s1_ready} !== 2'b10) begin
            $display("FAIL stall_resume_ready2: got %b want 10", {bus.s0_ready, bus.s1_ready});
            n_fail++;
        end
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_cmp++;
        if ({bus.w_enable, bus.w_addr, bus.w_data} !== {1'b1, 5'd8, 32'h0000_0088}) begin
            $display("FAIL stall_resume_w2: got en=%b addr=%0d data=%h want 1/8/00000088",
                     bus.w_enable, bus.w_addr, bus.w_data);
            n_fail++;
        end
        cyc();
    endtask

    task automatic test_reset_midop;
        drive(1'b1, 5'd4, 32'h0000_0044, 1'b0, '0, '0);
        cyc();
        n_cmp++;
        if (bus.w_enable !== 1'b1) begin
            $display("FAIL midop_pending: got en=%b want 1", bus.w_enable);
            n_fail++;
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 5'd6, 32'h0000_0066);
        n_cmp++;
        if ({bus.s0_ready, bus.s1_ready} !== 2'b00) begin
            $display("FAIL midop_ready: got %b want 00", {bus.s0_ready, bus.s1_ready});
            n_fail++;
        end
        cyc();
        n_cmp++;
        if ({bus.w_enable, bus.w_addr, bus.w_data} !== {1'b0, 5'd0, 32'h0}) begin
            $display("FAIL midop_w: got en=%b addr=%0d data=%h want 0/0/0",
                     bus.w_enable, bus.w_addr, bus.w_data);
            n_fail++;
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

`ifdef WB_SCOREBOARD_EN
    task automatic test_scoreboard;
        q1_addr   = 5'd3;
        q2_addr   = 5'd0;
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        #1;
        n_cmp++;
        if (q1_busy !== 1'b0) begin
            $display("FAIL sb_no_bypass: got %b want 0", q1_busy);
            n_fail++;
        end
        cyc();
        iss_valid = 1'b0;
        #1;
        n_cmp++;
        if (q1_busy !== 1'b1) begin
            $display("FAIL sb_set: got %b want 1", q1_busy);
            n_fail++;
        end
        // writeback to r3 accepted here, presented next cycle
        drive(1'b1, 5'd3, 32'h0000_0033, 1'b0, '0, '0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        // commit of r3 collides with a fresh issue to r3
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        cyc();
        iss_valid = 1'b0;
        #1;
        n_cmp++;
        if (q1_busy !== 1'b1) begin
            $display("FAIL sb_set_wins: got %b want 1", q1_busy);
            n_fail++;
        end
        drive(1'b1, 5'd3, 32'h0000_0333, 1'b0, '0, '0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cyc();
        n_cmp++;
        if (q1_busy !== 1'b0) begin
            $display("FAIL sb_clear: got %b want 0", q1_busy);
            n_fail++;
        end
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        cyc();
        iss_valid = 1'b0;
        #1;
        n_cmp++;
        if (q2_busy !== 1'b0) begin
            $display("FAIL sb_x0: got %b want 0", q2_busy);
            n_fail++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_addr_zero();
        test_stall();
        test_reset_midop();
`ifdef WB_SCOREBOARD_EN
        test_scoreboard();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
